// File: rtl/fact_bcd_conv.sv
// ---------------------------------------------------------------------------
// fact_bcd_conv
//
// Sequential binary-to-packed-BCD converter placed after the factorial unit.
// A request on `start` (the factorial `done`) captures `bin_in`. The result
// is then converted with shift-and-add-3 (double dabble), one input bit per
// clock. When the last bit has been shifted in, the result is written to
// `bcd_out` and `done` pulses for one cycle.
//
// Parameters
//   BIN_W   width of the binary input and number of shift iterations (>= 2)
//   DIGITS  number of BCD digits produced; 10**DIGITS must exceed 2**BIN_W-1
//
// Ports
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   start    in   conversion request, ignored while busy
//   bin_in   in   binary value, sampled together with start
//   busy     out  high while a conversion is in progress
//   done     out  one-cycle pulse when bcd_out is updated
//   bcd_out  out  packed BCD result, digit 0 (units) in [3:0], held between
//                 results
//
// Build option
//   FACT_BCD_LZB_EN  when defined, digits above the most significant non-zero
//                    digit are written as 4'hF (blank). Digit 0 is never
//                    blanked. Latency and handshake are the same in both
//                    builds.
// ---------------------------------------------------------------------------
module fact_bcd_conv #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int SCR_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [SCR_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    logic [SCR_W-1:0]   scratch_adj;
    logic [SCR_W-1:0]   scratch_shl;
    logic [BIN_W-1:0]   shift_shl;
    logic [SCR_W-1:0]   bcd_final;
    logic               last_iter;

    // Add-3 correction: each digit is corrected on its own, with no carry
    // into its neighbour. A digit of 5..9 becomes 8..12, so after the
    // following doubling its carry lands in the next digit up.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign scratch_adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5)
                                          ? scratch_q[gi*4 +: 4] + 4'd3
                                          : scratch_q[gi*4 +: 4];
        end
    endgenerate

    // Shift {scratch, shift register} left by one bit. The MSB of the input
    // shift register enters scratch bit 0.
    assign scratch_shl = {scratch_adj[SCR_W-2:0], shift_q[BIN_W-1]};
    assign shift_shl   = {shift_q[BIN_W-2:0], 1'b0};

`ifdef FACT_BCD_LZB_EN
    // Blank the leading zeros. The scan runs from the top digit downwards
    // and stops blanking at the first non-zero digit. Digit 0 is never
    // scanned, so a zero input still shows its units digit.
    logic seen_nz;
    always_comb begin
        seen_nz   = 1'b0;
        bcd_final = scratch_shl;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (scratch_shl[i*4 +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
            if (!seen_nz) begin
                bcd_final[i*4 +: 4] = 4'hF;
            end
        end
    end
`else
    assign bcd_final = scratch_shl;
`endif

    assign last_iter = (state_q == SHIFT) && (cnt_q == CNT_W'(BIN_W - 1));

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SHIFT;
                    shift_d   = bin_in;
                    scratch_d = '0;
                    cnt_d     = '0;
                end
            end
            SHIFT: begin
                shift_d   = shift_shl;
                scratch_d = scratch_shl;
                cnt_d     = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    state_d = IDLE;
                    bcd_d   = bcd_final;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == SHIFT);
    assign done    = done_q;
    assign bcd_out = bcd_q;

endmodule

// File: tb/tb_fact_bcd_conv.sv
// ---------------------------------------------------------------------------
// tb_fact_bcd_conv
//
// Self-checking bench for fact_bcd_conv with the default 16-bit / 5-digit
// parameters. The expected BCD values come from decimal arithmetic (repeated
// divide-by-ten). Inputs are driven and outputs are sampled on the falling
// clock edge.
// ---------------------------------------------------------------------------
module tb_fact_bcd_conv;

    localparam int BIN_W  = 16;
    localparam int DIGITS = 5;
    localparam int LAT    = BIN_W;

    logic                clk;
    logic                reset_n;
    logic                start;
    logic [BIN_W-1:0]    bin_in;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd_out;

    int errors = 0;
    int checks = 0;

    fact_bcd_conv #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Reference: decimal digits by division. The optional blanking replaces
    // every digit above the highest non-zero digit (digit 0 excluded).
    function automatic logic [19:0] ref_bcd(input int unsigned value);
        int unsigned v;
        int unsigned d[DIGITS];
        int          top;
        logic [19:0] r;
        v   = value;
        top = 0;
        for (int i = 0; i < DIGITS; i++) begin
            d[i] = v % 10;
            v    = v / 10;
            if (d[i] != 0) top = i;
        end
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(d[i]);
`ifdef FACT_BCD_LZB_EN
            if (i > top) r[i*4 +: 4] = 4'hF;
`endif
        end
        return r;
    endfunction

    // Called at a falling edge: presents a one-cycle start. The task returns
    // at the falling edge after the capture edge E0, with bin_in scrambled so
    // that any re-sampling would corrupt the result.
    task automatic start_conv(input logic [BIN_W-1:0] v);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start  = 1'b0;
        bin_in = BIN_W'($urandom);
    endtask

    // Waits for done, bounded by 40 cycles. n is the number of edges after
    // E0. The task also reports whether busy stayed high and bcd_out stayed
    // at 'held' until done.
    task automatic wait_done(input logic [19:0] held, output int n,
                             output bit busy_ok, output bit held_ok);
        n       = 0;
        busy_ok = 1'b1;
        held_ok = 1'b1;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            if (bcd_out !== held) held_ok = 1'b0;
        end
    endtask

    task automatic conv_check(input string tag, input logic [BIN_W-1:0] v);
        logic [19:0] prev;
        int          n;
        bit          bok, hok;
        prev = bcd_out;
        start_conv(v);
        wait_done(prev, n, bok, hok);
        check({tag, " latency"}, n, LAT);
        check({tag, " busy/hold"}, {30'd0, bok, hok}, 32'd3);
        check({tag, " bcd"}, bcd_out, ref_bcd(v));
        check({tag, " busy@done"}, busy, 0);
        @(negedge clk);
        check({tag, " done pulse"}, done, 0);
    endtask

    initial begin
        int          n, pulses, last_t, t;
        bit          bok, hok;
        logic [15:0] rv;

        reset_n = 1'b0;
        start   = 1'b0;
        bin_in  = '0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset bcd", bcd_out, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed values from the factorial range plus the extremes.
        conv_check("720", 16'd720);
        conv_check("24", 16'd24);
        conv_check("40320", 16'd40320);
        conv_check("65535", 16'd65535);
        conv_check("0", 16'd0);

        // A start during a running conversion is ignored.
        start_conv(16'd5040);
        n = 0;
        pulses = 0;
        while (n < 40) begin
            if (n == 4) begin start = 1'b1; bin_in = 16'd120; end
            else begin start = 1'b0; end
            @(negedge clk);
            n++;
            if (done) break;
        end
        start = 1'b0;
        check("ignore latency", n, LAT);
        check("ignore bcd", bcd_out, ref_bcd(5040));
        repeat (20) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("ignore extra done", pulses, 0);

        // A start in the cycle where done pulses is accepted on the next edge.
        start_conv(16'd720);
        wait_done(ref_bcd(5040), n, bok, hok);
        check("b2b first bcd", bcd_out, ref_bcd(720));
        start_conv(16'd24);
        wait_done(ref_bcd(720), n, bok, hok);
        check("b2b second latency", n, LAT);
        check("b2b held 720", {30'd0, bok, hok}, 32'd3);
        check("b2b second bcd", bcd_out, ref_bcd(24));
        @(negedge clk);

        // Reset in the middle of a conversion aborts it.
        start_conv(16'd40320);
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort bcd", bcd_out, 0);
        check("abort done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort no done", pulses, 0);
        conv_check("after abort", 16'd40320);

        // With start held high, a new conversion begins every BIN_W+1 cycles.
        start  = 1'b1;
        bin_in = 16'd720;
        t = 0;
        pulses = 0;
        last_t = 0;
        while (t < 100 && pulses < 3) begin
            @(negedge clk);
            t++;
            if (done) begin
                pulses++;
                if (pulses > 1) check("held period", t - last_t, LAT + 1);
                check("held bcd", bcd_out, ref_bcd(720));
                last_t = t;
            end
        end
        start = 1'b0;
        check("held pulses", pulses, 3);
        @(negedge clk);

        // Random values across the full input range.
        for (int k = 0; k < 20; k++) begin
            rv = 16'($urandom_range(0, 65535));
            conv_check($sformatf("rand %0d", rv), rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
